// File: rtl/bgd_mul_pkg.sv
// Shared constants and helpers for the BGD pipelined fixed-point multiplier.
package bgd_mul_pkg;

  localparam int BGD_MUL_MIN_STAGE = 3;

  function automatic int bgd_mul_pw(input int din0_width, input int din1_width);
    return din0_width + din1_width;
  endfunction

  function automatic logic signed [63:0] sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/bgd_mul_round_sat.sv
// Round-half-up rescale of the full product and fit to the output width.
// BGD_MUL_SAT_EN selects clamping on overflow; otherwise the result wraps.
module bgd_mul_round_sat
  import bgd_mul_pkg::*;
#(
  parameter int PW         = 28,
  parameter int FRAC_BITS  = 0,
  parameter int DOUT_WIDTH = 14
) (
  input  logic signed [PW-1:0]         p,
  output logic signed [DOUT_WIDTH-1:0] r_fit,
  output logic                         ovf
);

  localparam logic [PW:0]        ONE = (PW + 1)'(1);
  // Half an output LSB; shifting left then right yields 0 when FRAC_BITS is 0.
  localparam logic signed [PW:0] RND = $signed((ONE << FRAC_BITS) >> 1);

  logic signed [PW:0] sum;
  logic signed [PW:0] r;

  assign sum = {p[PW-1], p} + RND;
  assign r   = sum >>> FRAC_BITS;

  if (DOUT_WIDTH >= PW - FRAC_BITS + 1) begin : g_wide
    assign ovf   = 1'b0;
    assign r_fit = DOUT_WIDTH'(r);
  end else begin : g_fit
    logic fits;

    // R fits when every bit from the output sign position upward agrees.
    assign fits = (&r[PW:DOUT_WIDTH-1]) | ~(|r[PW:DOUT_WIDTH-1]);
    assign ovf  = ~fits;

`ifdef BGD_MUL_SAT_EN
    localparam logic signed [63:0]           MAX_W = sat_max(DOUT_WIDTH);
    localparam logic signed [63:0]           MIN_W = sat_min(DOUT_WIDTH);
    localparam logic signed [DOUT_WIDTH-1:0] MAX_V = MAX_W[DOUT_WIDTH-1:0];
    localparam logic signed [DOUT_WIDTH-1:0] MIN_V = MIN_W[DOUT_WIDTH-1:0];
`endif

    always_comb begin
      // NOTE: default first so every path assigns r_fit and no latch is inferred.
      r_fit = r[DOUT_WIDTH-1:0];
`ifdef BGD_MUL_SAT_EN
      if (!fits) r_fit = r[PW] ? MIN_V : MAX_V;
`endif
    end
  end

endmodule

// File: rtl/bgd_mul_pipe.sv
// Parametrised pipelined signed fixed-point multiplier with valid tracking,
// round-half-up rescaling and overflow flag. Build macro: BGD_MUL_SAT_EN.
module bgd_mul_pipe
  import bgd_mul_pkg::*;
#(
  parameter int DIN0_WIDTH = 14,
  parameter int DIN1_WIDTH = 14,
  parameter int DOUT_WIDTH = 14,
  parameter int FRAC_BITS  = 0,
  parameter int NUM_STAGE  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         din_vld,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         dout_vld,
  output logic                         ovf
);

  localparam int PW   = bgd_mul_pw(DIN0_WIDTH, DIN1_WIDTH);
  localparam int LAST = NUM_STAGE - 3;

  if (NUM_STAGE < BGD_MUL_MIN_STAGE) begin : g_bad_stage
    $error("bgd_mul_pipe: NUM_STAGE must be at least %0d", BGD_MUL_MIN_STAGE);
  end
  if (FRAC_BITS < 0 || FRAC_BITS >= PW) begin : g_bad_frac
    $error("bgd_mul_pipe: FRAC_BITS out of range");
  end

  logic signed [DIN0_WIDTH-1:0] a_q;
  logic signed [DIN1_WIDTH-1:0] b_q;
  logic                         v1_q;

  // Index 0 is the product register; higher indices are pure delay stages.
  logic signed [PW-1:0] p_pipe [LAST+1];
  logic [LAST:0]        v_pipe;

  logic signed [DOUT_WIDTH-1:0] r_fit;
  logic                         ovf_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
      a_q  <= '0;
      b_q  <= '0;
      v1_q <= 1'b0;
    end else if (ce) begin
      a_q  <= din0;
      b_q  <= din1;
      v1_q <= din_vld;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: pipeline data is cleared too, so reset leaves no stale operands behind.
      p_pipe[0] <= '0;
      v_pipe[0] <= 1'b0;
    end else if (ce) begin
      p_pipe[0] <= PW'(a_q) * PW'(b_q);
      v_pipe[0] <= v1_q;
    end
  end

  for (genvar j = 1; j <= LAST; j++) begin : g_dly
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        p_pipe[j] <= '0;
        v_pipe[j] <= 1'b0;
      end else if (ce) begin
        p_pipe[j] <= p_pipe[j-1];
        v_pipe[j] <= v_pipe[j-1];
      end
    end
  end

  bgd_mul_round_sat #(
    .PW         (PW),
    .FRAC_BITS  (FRAC_BITS),
    .DOUT_WIDTH (DOUT_WIDTH)
  ) u_round_sat (
    .p     (p_pipe[LAST]),
    .r_fit (r_fit),
    .ovf   (ovf_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout     <= '0;
      dout_vld <= 1'b0;
      ovf      <= 1'b0;
    end else if (ce) begin
      dout     <= r_fit;
      dout_vld <= v_pipe[LAST];
      ovf      <= ovf_c;
    end
  end

endmodule

// File: tb/tb_bgd_mul_pipe.sv
// Scoreboard bench for bgd_mul_pipe: two instances (FRAC 0 / NUM_STAGE 4 and
// FRAC 7 / NUM_STAGE 5) share stimulus; a monitor checks every accepted edge.
module tb_bgd_mul_pipe;

  localparam int W     = 14;
  localparam int NDUT  = 2;
  localparam int FRAC1 = 7;
  localparam int NS0   = 4;
  localparam int NS1   = 5;

  typedef struct {
    logic [W-1:0] dout;
    logic         ovf;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         ce;
  logic         din_vld;
  logic [W-1:0] din0;
  logic [W-1:0] din1;

  logic [W-1:0] dout_w [NDUT];
  logic         vld_w  [NDUT];
  logic         ovf_w  [NDUT];

  exp_t sb [NDUT][$];

  int n_checks = 0;
  int n_fail   = 0;
  int acc_cnt  = 0;
  bit accepted;
  bit stalled;

  logic [W-1:0] last_dout [NDUT];
  logic         last_vld  [NDUT];
  logic         last_ovf  [NDUT];

  always #5 clk = ~clk;

  bgd_mul_pipe #(
    .DIN0_WIDTH(W), .DIN1_WIDTH(W), .DOUT_WIDTH(W), .FRAC_BITS(0), .NUM_STAGE(NS0)
  ) u_dut0 (
    .clk(clk), .reset(reset), .ce(ce), .din_vld(din_vld), .din0(din0), .din1(din1),
    .dout(dout_w[0]), .dout_vld(vld_w[0]), .ovf(ovf_w[0])
  );

  bgd_mul_pipe #(
    .DIN0_WIDTH(W), .DIN1_WIDTH(W), .DOUT_WIDTH(W), .FRAC_BITS(FRAC1), .NUM_STAGE(NS1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .ce(ce), .din_vld(din_vld), .din0(din0), .din1(din1),
    .dout(dout_w[1]), .dout_vld(vld_w[1]), .ovf(ovf_w[1])
  );

  function automatic int frac_of(input int i);
    return (i == 0) ? 0 : FRAC1;
  endfunction

  function automatic int ns_of(input int i);
    return (i == 0) ? NS0 : NS1;
  endfunction

  // Reference: exact product, round half up by adding half an LSB then flooring.
  function automatic exp_t model(input int frac, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint p;
    longint r;
    longint hi;
    longint lo;
    p  = longint'($signed(a)) * longint'($signed(b));
    if (frac > 0) r = (p + (longint'(1) <<< (frac - 1))) >>> frac;
    else          r = p;
    hi = (longint'(1) <<< (W - 1)) - 1;
    lo = -(longint'(1) <<< (W - 1));
    e.ovf  = (r > hi) || (r < lo);
    e.dout = r[W-1:0];
`ifdef BGD_MUL_SAT_EN
    if (e.ovf) e.dout = (r > 0) ? hi[W-1:0] : lo[W-1:0];
`endif
    e.due = 0;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c);
    exp_t e;
    @(negedge clk);
    din_vld = v;
    din0    = a;
    din1    = b;
    ce      = c;
    if (v && c && reset) begin
      for (int i = 0; i < NDUT; i++) begin
        e     = model(frac_of(i), a, b);
        e.due = acc_cnt + ns_of(i);
        sb[i].push_back(e);
      end
    end
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 14'h1FFF;
      1:       return 14'h2000;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic check_zero(input string tag);
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("%s_dut%0d_dout", tag, i), 64'(dout_w[i]), 64'd0);
      check($sformatf("%s_dut%0d_vld", tag, i), 64'(vld_w[i]), 64'd0);
      check($sformatf("%s_dut%0d_ovf", tag, i), 64'(ovf_w[i]), 64'd0);
    end
  endtask

  // Monitor: on each accepted edge the head entry either is due now or the
  // output must be a bubble; on stalled edges every output must hold.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      accepted = ce && reset;
      stalled  = !ce && reset;
      if (accepted) acc_cnt++;
      @(negedge clk);
      if (reset) begin
        for (int i = 0; i < NDUT; i++) begin
          if (stalled) begin
            check($sformatf("hold_dut%0d_dout", i), 64'(dout_w[i]), 64'(last_dout[i]));
            check($sformatf("hold_dut%0d_vld", i), 64'(vld_w[i]), 64'(last_vld[i]));
            check($sformatf("hold_dut%0d_ovf", i), 64'(ovf_w[i]), 64'(last_ovf[i]));
          end else if (accepted) begin
            if (sb[i].size() > 0 && sb[i][0].due == acc_cnt) begin
              e = sb[i].pop_front();
              check($sformatf("dut%0d_vld@%0d", i, acc_cnt), 64'(vld_w[i]), 64'd1);
              check($sformatf("dut%0d_dout@%0d", i, acc_cnt), 64'(dout_w[i]), 64'(e.dout));
              check($sformatf("dut%0d_ovf@%0d", i, acc_cnt), 64'(ovf_w[i]), 64'(e.ovf));
            end else begin
              check($sformatf("dut%0d_bubble@%0d", i, acc_cnt), 64'(vld_w[i]), 64'd0);
            end
          end
        end
      end
      for (int i = 0; i < NDUT; i++) begin
        last_dout[i] = dout_w[i];
        last_vld[i]  = vld_w[i];
        last_ovf[i]  = ovf_w[i];
      end
    end
  end

  int dir_a [8] = '{1, -1, 128, -1, 8191, -8192, -8192, 0};
  int dir_b [8] = '{64, 64, 256, 192, 8191, -8192, 8191, 0};

  initial begin
    reset   = 1'b0;
    ce      = 1'b1;
    din_vld = 1'b1;
    din0    = 14'd5;
    din1    = 14'd7;
    repeat (3) @(negedge clk);
    #1 check_zero("reset");
    reset   = 1'b1;
    din_vld = 1'b0;

    // Latency/throughput stream
    for (int k = 1; k <= 20; k++) drive(1'b1, W'(k), W'(3), 1'b1);

    // Rounding and overflow corner vectors
    for (int k = 0; k < 8; k++) drive(1'b1, W'(dir_a[k]), W'(dir_b[k]), 1'b1);

    // Bubbles
    for (int k = 0; k < 12; k++) drive(k[0] == 1'b0, rand_op(), rand_op(), 1'b1);

    // Stall with results in flight and one already presented
    for (int k = 0; k < 5; k++) drive(1'b1, rand_op(), rand_op(), 1'b1);
    for (int k = 0; k < 3; k++) drive(1'b1, rand_op(), rand_op(), 1'b0);
    for (int k = 0; k < 8; k++) drive(1'b0, rand_op(), rand_op(), 1'b1);

    // Random traffic with random stalls
    for (int k = 0; k < 300; k++)
      drive($urandom_range(0, 3) != 0, rand_op(), rand_op(), $urandom_range(0, 4) != 0);

    // Reset mid-stream
    for (int k = 0; k < 3; k++) drive(1'b1, rand_op(), rand_op(), 1'b1);
    @(negedge clk);
    reset   = 1'b0;
    din_vld = 1'b0;
    ce      = 1'b1;
    #1 check_zero("midreset");
    for (int i = 0; i < NDUT; i++) sb[i].delete();
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < NS1 + 2; k++) drive(1'b0, rand_op(), rand_op(), 1'b1);

    // Post-reset traffic then drain
    for (int k = 0; k < 10; k++) drive(1'b1, rand_op(), rand_op(), 1'b1);
    for (int k = 0; k < 12; k++) drive(1'b0, 14'd0, 14'd0, 1'b1);
    @(negedge clk);
    for (int i = 0; i < NDUT; i++)
      check($sformatf("drain_dut%0d_pending", i), 64'(sb[i].size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
